// File: rtl/cram_loader_pkg.sv
// Shared CRAM loader definitions: geometry, diag function codes, FSM states.
package cram_loader_pkg;

  localparam int CRAM_ADDR_W  = 11;
  localparam int CRAM_WORD_W  = 84;
  localparam int CRAM_CHUNK_W = 14;

  localparam logic [2:0] DIAG_LDADR  = 3'd0;
  localparam logic [2:0] DIAG_LDDATA = 3'd1;
  localparam logic [2:0] DIAG_WRITE  = 3'd2;
  localparam logic [2:0] DIAG_CLRERR = 3'd3;

  typedef enum logic [2:0] {
    LD_IDLE    = 3'd0,
    LD_COLLECT = 3'd1,
    LD_WRITE   = 3'd2,
    LD_VERIFY  = 3'd3,
    LD_DONE    = 3'd4
  } ld_state_t;

endpackage

// File: rtl/cram_word_asm.sv
// Microword assembly: chunk counter plus the register that builds the word.
// Chunk 0 lands in the MSB end (bit 0) of the ascending-numbered word.
module cram_word_asm
  import cram_loader_pkg::*;
#(
  parameter int WORD_W  = CRAM_WORD_W,
  parameter int CHUNK_W = CRAM_CHUNK_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               load,
  input  logic [CHUNK_W-1:0] chunk,
  output logic [0:WORD_W-1]  word,
  output logic               full
);

  localparam int NCHUNK = WORD_W / CHUNK_W;
  localparam int CNT_W  = $clog2(NCHUNK + 1);

  logic [CNT_W-1:0] cnt;

  assign full = (cnt == CNT_W'(NCHUNK));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      word <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load && !full) begin
      word[int'(cnt)*CHUNK_W +: CHUNK_W] <= chunk;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cram_loader.sv
// Diagnostic-bus CRAM writer: assembles six chunks, commits with one strobe.
// Define CRAM_LOAD_VERIFY_EN to add a readback VERIFY state.
module cram_loader
  import cram_loader_pkg::*;
#(
  parameter int ADDR_W  = CRAM_ADDR_W,
  parameter int WORD_W  = CRAM_WORD_W,
  parameter int CHUNK_W = CRAM_CHUNK_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               diagStrobe,
  input  logic [2:0]         diagFunc,
  input  logic [CHUNK_W-1:0] diagData,
  output logic               busy,
  output logic               done,
  output logic               seqErr,
  output logic               cramWe,
  output logic [ADDR_W-1:0]  cramAdr,
  output logic [0:WORD_W-1]  cramWd,
  input  logic [0:WORD_W-1]  cramRd,
  output logic               verifyErr
);

  ld_state_t state;
  logic      busy_st;
  logic      is_ldadr;
  logic      is_lddata;
  logic      is_write;
  logic      is_clrerr;
  logic      word_full;
  logic      asm_clr;

  assign busy_st = (state == LD_WRITE) ||
                   (state == LD_VERIFY) ||
                   (state == LD_DONE);

  assign is_ldadr  = diagStrobe && !busy_st
                     && (diagFunc == DIAG_LDADR);
  assign is_lddata = diagStrobe && !busy_st
                     && (diagFunc == DIAG_LDDATA);
  assign is_write  = diagStrobe && !busy_st
                     && (diagFunc == DIAG_WRITE);
  assign is_clrerr = diagStrobe
                     && (diagFunc == DIAG_CLRERR);

  assign asm_clr = is_ldadr || (state == LD_DONE);

  cram_word_asm #(
    .WORD_W  (WORD_W),
    .CHUNK_W (CHUNK_W)
  ) u_asm (
    .clk   (clk),
    .reset (reset),
    .clr   (asm_clr),
    .load  (is_lddata),
    .chunk (diagData),
    .word  (cramWd),
    .full  (word_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= LD_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      seqErr  <= 1'b0;
      cramWe  <= 1'b0;
      cramAdr <= '0;
    end else begin
      cramWe <= 1'b0;
      done   <= 1'b0;
      // a clear loses to an error raised in the same cycle
      if (is_clrerr)
        seqErr <= 1'b0;
      if (diagStrobe && busy_st && diagFunc != DIAG_CLRERR)
        seqErr <= 1'b1;
      unique case (state)
        LD_IDLE, LD_COLLECT: begin
          if (is_ldadr) begin
            cramAdr <= diagData[ADDR_W-1:0];
            state   <= LD_IDLE;
          end
          if (is_lddata) begin
            if (word_full) seqErr <= 1'b1;
            else           state  <= LD_COLLECT;
          end
          if (is_write) begin
            if (word_full) begin
              state  <= LD_WRITE;
              cramWe <= 1'b1;
              busy   <= 1'b1;
            end else begin
              seqErr <= 1'b1;
            end
          end
        end
        LD_WRITE: begin
`ifdef CRAM_LOAD_VERIFY_EN
          state <= LD_VERIFY;
`else
          state <= LD_DONE;
          done  <= 1'b1;
`endif
        end
        LD_VERIFY: begin
          state <= LD_DONE;
          done  <= 1'b1;
        end
        LD_DONE: begin
          state   <= LD_IDLE;
          busy    <= 1'b0;
          cramAdr <= cramAdr + 1'b1;
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

  logic unused_data;
  assign unused_data = ^diagData;

`ifdef CRAM_LOAD_VERIFY_EN
  // readback for the held address arrives in the DONE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      verifyErr <= 1'b0;
    end else begin
      if (is_clrerr)
        verifyErr <= 1'b0;
      if (state == LD_DONE && cramRd != cramWd)
        verifyErr <= 1'b1;
    end
  end
`else
  logic unused_rd;
  assign unused_rd = ^cramRd;
  assign verifyErr = 1'b0;
`endif

endmodule
